// File: rtl/bcd_led_pkg.sv
// Purpose : shared constants for the multiplexed BCD seven-segment driver.
//           Segment words are active-low, bit0=a .. bit6=g.
// Contents: SEG_BLANK, SEG_DASH, SEG_TABLE (16 entries indexed by 4-bit code).
package bcd_led_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Entry k lives at SEG_TABLE[k]; codes 10..15 are not BCD and show a dash.
   localparam logic [15:0][6:0] SEG_TABLE = {
      {6{SEG_DASH}},
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

endpackage

// File: rtl/bcd_seg_dec.sv
// Purpose : combinational 4-bit code to active-low seven-segment decoder.
// Ports   : code - 4-bit BCD code (10..15 decode to a dash)
//           seg  - 7-bit active-low segments, bit0=a .. bit6=g
module bcd_seg_dec
   import bcd_led_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[code];

endmodule

// File: rtl/bcd_scan_led.sv
// Purpose : time-multiplexed driver for N_DIGITS common-anode seven-segment
//           displays with frame-synchronous loading, leading-zero blanking,
//           per-digit blink and a global dark control.
// Ports   : CLK        - clock, all state on rising edge
//           RST        - synchronous active-high reset
//           DIGITS     - BCD digits, digit i on [4i+3:4i]
//           LOAD       - one-cycle strobe capturing DIGITS
//           BLANK_LZ   - leading-zero blanking enable
//           BLINK_MASK - per-digit blink enable
//           OFF        - force all displays dark
//           LED        - registered active-low segments (bit0=a .. bit6=g)
//           AN         - registered active-low digit enables
//           FRAME      - one-cycle pulse after each frame boundary
module bcd_scan_led
   import bcd_led_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [4*N_DIGITS-1:0]   DIGITS,
   input  logic                    LOAD,
   input  logic                    BLANK_LZ,
   input  logic [N_DIGITS-1:0]     BLINK_MASK,
   input  logic                    OFF,
   output logic [6:0]              LED,
   output logic [N_DIGITS-1:0]     AN,
   output logic                    FRAME
);

   localparam int PRESC_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
   localparam int IDX_W   = (N_DIGITS > 1)     ? $clog2(N_DIGITS)     : 1;
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PRESC_W-1:0]          presc;
   logic [IDX_W-1:0]            idx;
   logic [N_DIGITS-1:0][3:0]    pending;
   logic [N_DIGITS-1:0][3:0]    display;
   logic [BLINK_W-1:0]          blink_cnt;
   logic                        phase;

   logic                        scan_tick;
   logic                        frame_edge;
   logic [N_DIGITS-1:0]         lz;
   logic                        zero_run;
   logic [3:0]                  cur_code;
   logic [6:0]                  dec_seg;
   logic                        blank_cur;

   logic [6:0]                  led_p1;
   logic [N_DIGITS-1:0]         an_p1;
   logic                        frame_p1;

   assign scan_tick  = (presc == PRESC_W'(SCAN_DIV - 1));
   assign frame_edge = scan_tick && (idx == IDX_W'(N_DIGITS - 1));

   // Scan timing, frame-synchronous display update and blink phase.
   always_ff @(posedge CLK) begin
      if (RST) begin
         presc     <= '0;
         idx       <= '0;
         pending   <= '0;
         display   <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else begin
         presc <= scan_tick ? '0 : presc + PRESC_W'(1);
         if (scan_tick)
            idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         if (LOAD)
            pending <= DIGITS;
         // A LOAD on the boundary cycle bypasses pending so it shows this frame.
         if (frame_edge)
            display <= LOAD ? DIGITS : pending;
         if (frame_edge) begin
            if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + BLINK_W'(1);
            end
         end
      end
   end

   // Digit i>0 is a leading zero when it and every higher digit are zero.
   always_comb begin
      lz       = '0;
      zero_run = 1'b1;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (display[i] == 4'd0);
         if (i > 0)
            lz[i] = zero_run;
      end
   end

   assign cur_code  = display[idx];
   assign blank_cur = (BLANK_LZ && lz[idx]) || (phase && BLINK_MASK[idx]);

   bcd_seg_dec u_dec (
      .code (cur_code),
      .seg  (dec_seg)
   );

   // Output register stage: LED and AN update together from the same slot.
   always_ff @(posedge CLK) begin
      if (RST) begin
         led_p1   <= SEG_BLANK;
         an_p1    <= '1;
         frame_p1 <= 1'b0;
      end else begin
         frame_p1 <= frame_edge;
         if (OFF) begin
            led_p1 <= SEG_BLANK;
            an_p1  <= '1;
         end else begin
            led_p1 <= blank_cur ? SEG_BLANK : dec_seg;
            an_p1  <= ~(N_DIGITS'(1) << idx);
         end
      end
   end

   assign LED   = led_p1;
   assign AN    = an_p1;
   assign FRAME = frame_p1;

endmodule

// File: tb/tb_bcd_scan_led.sv
// Directed bench for bcd_scan_led with N_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// cyc counts rising edges since the last reset edge; outputs are sampled
// 1 time unit after each edge, so after edge k they show the slot whose
// index was ((k-1)/4)%4, and frame boundaries fall on edges 16, 32, ...
module tb_bcd_scan_led;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] DIGITS = '0;
   logic        LOAD = 1'b0;
   logic        BLANK_LZ = 1'b0;
   logic [3:0]  BLINK_MASK = '0;
   logic        OFF = 1'b0;
   logic [6:0]  LED;
   logic [3:0]  AN;
   logic        FRAME;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   bcd_scan_led #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .DIGITS     (DIGITS),
      .LOAD       (LOAD),
      .BLANK_LZ   (BLANK_LZ),
      .BLINK_MASK (BLINK_MASK),
      .OFF        (OFF),
      .LED        (LED),
      .AN         (AN),
      .FRAME      (FRAME)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int k);
      while (cyc < k) tick();
   endtask

   task automatic slot(input string tag, input int k, input logic [3:0] an_exp, input logic [6:0] led_exp);
      run_to(k);
      chk({tag, "_an"}, {12'd0, AN}, {12'd0, an_exp});
      chk({tag, "_led"}, {9'd0, LED}, {9'd0, led_exp});
   endtask

   task automatic frm(input string tag, input int k, input logic exp);
      run_to(k);
      chk(tag, {15'd0, FRAME}, {15'd0, exp});
   endtask

   // LOAD is sampled by edge k.
   task automatic load_at(input int k, input logic [15:0] d);
      run_to(k - 1);
      DIGITS = d;
      LOAD   = 1'b1;
      tick();
      LOAD   = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      slot("rst_hold", cyc, 4'b1111, SB);
      frm("rst_hold_frame", cyc, 1'b0);
      cyc = 0;
      RST = 1'b0;
      // Cycle after reset is still dark.
      slot("rst_after", 0, 4'b1111, SB);

      // Basic scan of 1234 loaded on cycle 1.
      load_at(1, 16'h1234);
      frm("frame15", 15, 1'b0);
      frm("frame16", 16, 1'b1);
      slot("old_d3", 16, 4'b0111, S0);
      frm("frame17", 17, 1'b0);
      slot("scan_d0", 17, 4'b1110, S4);
      slot("scan_d1", 21, 4'b1101, S3);
      slot("scan_d2", 25, 4'b1011, S2);
      slot("scan_d3", 29, 4'b0111, S1);
      frm("frame32", 32, 1'b1);
      slot("scan2_d0", 33, 4'b1110, S4);
      slot("scan2_d1", 37, 4'b1101, S3);

      // Mid-frame load waits for the boundary.
      load_at(40, 16'h5555);
      slot("tear_d2", 41, 4'b1011, S2);
      slot("tear_d3", 45, 4'b0111, S1);
      frm("frame48", 48, 1'b1);
      slot("new_d0", 49, 4'b1110, S5);

      // Load on the boundary edge applies that frame; last of many wins.
      load_at(64, 16'h6789);
      slot("bnd_d0", 65, 4'b1110, S9);
      load_at(67, 16'h1111);
      load_at(70, 16'h2222);
      slot("bnd_d2", 73, 4'b1011, S7);
      slot("bnd_d3", 77, 4'b0111, S6);
      slot("last_wins", 81, 4'b1110, S2);

      // Leading-zero blanking.
      load_at(96, 16'h0070);
      BLANK_LZ = 1'b1;
      slot("lz_d0", 97, 4'b1110, S0);
      slot("lz_d1", 101, 4'b1101, S7);
      slot("lz_d2", 105, 4'b1011, SB);
      slot("lz_d3", 109, 4'b0111, SB);
      load_at(112, 16'h0000);
      slot("lz0_d0", 113, 4'b1110, S0);
      slot("lz0_d1", 117, 4'b1101, SB);
      slot("lz0_d3", 125, 4'b0111, SB);

      // Blink: phase toggles on boundaries 32, 64, 96, 128, 160, 192.
      load_at(128, 16'h00AF);
      BLANK_LZ   = 1'b0;
      BLINK_MASK = 4'b0001;
      slot("blk_on_d0", 129, 4'b1110, SD);
      slot("blk_on_d1", 133, 4'b1101, SD);
      slot("blk_on2_d0", 145, 4'b1110, SD);
      slot("blk_off_d0", 161, 4'b1110, SB);
      slot("blk_off_d1", 165, 4'b1101, SD);
      slot("blk_off2_d0", 177, 4'b1110, SB);
      slot("blk_back_d0", 193, 4'b1110, SD);

      // OFF for edges 203..212; scan keeps running underneath.
      run_to(202);
      OFF = 1'b1;
      slot("off_first", 203, 4'b1111, SB);
      frm("off_frame", 208, 1'b1);
      slot("off_mid", 208, 4'b1111, SB);
      slot("off_last", 212, 4'b1111, SB);
      OFF = 1'b0;
      slot("off_resume", 213, 4'b1101, SD);
      frm("off_frame224", 224, 1'b1);

      // Reset mid-frame with a pending load.
      load_at(226, 16'h9999);
      BLINK_MASK = 4'b0000;
      run_to(230);
      RST = 1'b1;
      tick();
      slot("rst2_dark", cyc, 4'b1111, SB);
      frm("rst2_frame", cyc, 1'b0);
      RST = 1'b0;
      cyc = 0;
      slot("rst2_d0", 1, 4'b1110, S0);
      frm("rst2_f15", 15, 1'b0);
      frm("rst2_f16", 16, 1'b1);
      slot("rst2_nd0", 17, 4'b1110, S0);
      slot("rst2_nd1", 21, 4'b1101, S0);
      slot("rst2_nd3", 29, 4'b0111, S0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bcd_scan_led.md
BCD_SCAN_LED -- requirements
Module: bcd_scan_led

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, number of BCD digits/displays (legal 1..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, CLK cycles per digit slot (legal >= 2).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 32, full scan frames per blink half-period (legal >= 1).
REQ-004 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 DIGITS  input  4*N_DIGITS  BCD digits, digit i on bits [4i+3:4i], digit 0 least significant.
REQ-007 LOAD  input  1  one-cycle strobe capturing DIGITS.
REQ-008 BLANK_LZ  input  1  leading-zero blanking enable.
REQ-009 BLINK_MASK  input  N_DIGITS  per-digit blink enable.
REQ-010 OFF  input  1  all displays dark while 1.
REQ-011 LED  output  7  segments, active-low, bit0=a … bit6=g (a top, b upper-right, c lower-right, d bottom, e lower-left, f upper-left, g middle).
REQ-012 AN  output  N_DIGITS  digit enables, active-low, one-hot-low while lit.
REQ-013 FRAME  output  1  one-cycle pulse at each frame start.

Function
REQ-014 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; at its terminal count the digit index SHALL advance by 1 modulo N_DIGITS.
REQ-015 Index wrap from N_DIGITS-1 to 0 SHALL be a frame boundary; FRAME SHALL pulse high for exactly the cycle after that edge.
REQ-016 LOAD=1 SHALL capture DIGITS into a pending register; the display register SHALL copy pending only at a frame boundary (no mid-frame tearing).
REQ-017 LOAD=1 coincident with a frame boundary SHALL load DIGITS directly into both pending and display registers.
REQ-018 Multiple LOADs within one frame: last one wins.
REQ-019 Decode: 0..9 standard active-low patterns (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000); codes 10..15 SHALL show dash 0111111.
REQ-020 With BLANK_LZ=1, digit i>0 SHALL be blank (LED=1111111, AN bit still low) when it and all higher digits are 0; digit 0 is never blanked.
REQ-021 A blink phase bit SHALL toggle every BLINK_FRAMES frame boundaries; while phase=1, digits with BLINK_MASK bit set SHALL be blank.
REQ-022 OFF=1 SHALL force LED=1111111 and AN all ones from the next cycle; prescaler, index, blink phase, and loading continue unaffected.
REQ-023 LED and AN SHALL be registered, reflecting index/display state with one-cycle latency; both change in the same cycle, never glitching between slots.

Reset
REQ-024 RST=1 SHALL clear prescaler, index, pending and display registers, and blink phase to 0 in the same cycle.
REQ-025 During and on the cycle after RST: LED=1111111, AN all ones, FRAME=0.
REQ-026 RST mid-frame SHALL discard a pending LOAD; first post-reset frame boundary occurs N_DIGITS*SCAN_DIV cycles after release.

Structure
REQ-027 Package bcd_led_pkg SHALL hold the 16-entry segment constant table, SEG_BLANK (1111111) and SEG_DASH constants.
REQ-028 Decode SHALL be a combinational sub-module bcd_seg_dec (4-bit code in, 7-bit active-low segments out), instantiated once.

Verification (N_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-029 Reset release, LOAD DIGITS=16'h1234 on cycle 1 -> after first frame, AN cycles 1110,1101,1011,0111 each 4 cycles, LED 0011001,0110000,0100100,1111001; FRAME every 16 cycles.
REQ-030 BLANK_LZ=1, DIGITS=16'h0070 -> digits 3,2 blank, digit 1 = 1111000, digit 0 = 1000000; DIGITS=16'h0000 -> only digit 0 lit as 0.
REQ-031 LOAD 16'h5555 mid-frame -> current frame keeps old value, change appears exactly at next FRAME; LOAD on boundary cycle -> applied that frame.
REQ-032 BLINK_MASK=4'b0001, DIGITS=16'h00AF -> digits 1,0 show dash; digit 0 dark for 2 frames, lit for 2 frames, repeating.
REQ-033 OFF=1 for 10 cycles mid-scan -> LED/AN dark, on release index continues where the free-running counter is (no restart).
REQ-034 RST asserted mid-frame with pending LOAD -> outputs dark next cycle, display shows 0000 afterward.
